mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the single-ported unified instruction/data memory shared by the instruction fetch stage and the load/store stage.
- Arbitrates between the two requesters, issues one memory access at a time, waits a fixed latency and returns read data with a one-cycle acknowledge.
- Drives `if_stall` and `d_stall`, which the core uses to gate `pcenable`/`ifrenable` while an access is outstanding.

Parameters:
- MEM_LAT, 2, cycles from the `mem_en` cycle to the cycle in which `mem_rdata` is valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held with `if_addr` until `if_ack`
- if_addr  input  32  fetch byte address
- if_ack  output  1  one-cycle pulse; `if_rdata` valid in the same cycle
- if_rdata  output  32  fetched instruction word
- if_stall  output  1  `if_req & ~if_ack` (combinational)
- d_req  input  1  data request; held with `d_we`/`d_addr`/`d_wdata` until `d_ack`
- d_we  input  1  1 = store, 0 = load
- d_addr  input  32  data byte address
- d_wdata  input  32  store data
- d_ack  output  1  one-cycle pulse; `d_rdata` valid in the same cycle
- d_rdata  output  32  load data; 0 for stores
- d_stall  output  1  `d_req & ~d_ack` (combinational)
- mem_en  output  1  access strobe, exactly one cycle per transaction
- mem_we  output  1  write enable, qualified by `mem_en`
- mem_addr  output  32  registered access address
- mem_wdata  output  32  registered write data
- mem_rdata  input  32  memory read data, valid MEM_LAT cycles after `mem_en`

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, ACK. A 4-bit counter counts WAIT cycles. `last_grant` register: 0 = IF, 1 = D.
- Reset (synchronous, any state including mid-transaction):
  - state=IDLE, counter=0, last_grant=0 (IF).
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `if_ack`=0, `d_ack`=0, `if_rdata`=0, `d_rdata`=0.
  - Any in-flight access is abandoned: no ack and no late data capture.
- IDLE:
  - No request: stay in IDLE; `mem_en` stays 0.
  - Only one request: grant it.
  - Both requests: grant the requester that was NOT `last_grant`. After reset, data wins the first conflict.
  - On a grant: register addr/we/wdata (for IF, we=0 and wdata=0), update `last_grant`, go to ISSUE.
- ISSUE (1 cycle): `mem_en`=1, with `mem_we`/`mem_addr`/`mem_wdata` from the registers; counter := MEM_LAT; go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where counter==1, capture `mem_rdata` (captured as 0 for stores) at the clock edge and go to ACK.
- ACK (1 cycle):
  - Assert the granted requester's ack; its rdata output holds the captured word.
  - The other requester's ack stays 0.
  - Go to IDLE. Always one IDLE bubble between transactions.
- Latency: a request first seen in IDLE at cycle T gets its ack at cycle T+2+MEM_LAT. With MEM_LAT=2, that is 4 cycles.
- `mem_addr`, `mem_we` and `mem_wdata` hold their last values outside ISSUE; only `mem_en` qualifies them.
- `if_rdata`/`d_rdata` hold their last captured value until the next capture for that port.
- Requester drops its request mid-transaction (protocol violation): the transaction still completes and the ack is still pulsed.
- Requester holds its request through ack: treated as a new request in the following IDLE and subject to arbitration.
- The arbiter never issues back-to-back `mem_en` cycles. Minimum spacing between `mem_en` pulses is MEM_LAT+3 cycles.
- Address alignment and bounds are not checked; addresses are passed through unchanged.

Test Plan:
- MEM_LAT=2, only `if_req`=1 at cycle 0, `if_addr`=0x00000040, `mem_rdata`=0x8C220004 in cycle 3:
  - `mem_en`=1 in cycle 1 with `mem_addr`=0x40 and `mem_we`=0.
  - `if_ack`=1 in cycle 4 with `if_rdata`=0x8C220004.
  - `if_stall`=1 in cycles 0-3.
- Just after reset, `if_req`=`d_req`=1 in the same cycle (load, `d_addr`=0x100):
  - Data is granted first: `d_ack` in cycle 4.
  - Fetch is granted in the next IDLE (cycle 5): `if_ack` in cycle 9.
  - `if_stall` stays 1 throughout.
- Both requests held continuously for 4 transactions: grants alternate D, IF, D, IF; `mem_en` pulses spaced exactly 5 cycles apart.
- Store with `d_we`=1, `d_addr`=0x200, `d_wdata`=0xDEADBEEF:
  - ISSUE cycle shows `mem_en`=1, `mem_we`=1, `mem_addr`=0x200, `mem_wdata`=0xDEADBEEF.
  - `d_ack`=1 with `d_rdata`=0.
- Reset asserted for 1 cycle during WAIT: the next cycle has state IDLE and all outputs 0; no ack follows; a subsequent conflict again grants data first.
- MEM_LAT=1 instantiation, single fetch: `mem_en` in cycle 1, `mem_rdata` sampled in cycle 2, `if_ack` in cycle 3.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch / load-store requesters, the shared memory
// and the arbiter. The arbiter uses the slave view; everything around it uses master.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_stall;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_stall;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store:
// one access at a time, fixed read latency, one-cycle ack back to the winner.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic        last_grant_reg;     // 0 = fetch, 1 = data; also selects the ack
    logic        we_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [31:0] if_rdata_reg, d_rdata_reg;
    logic        req_any, pick_d;

    assign req_any = bus.if_req | bus.d_req;
    // On a conflict the side that did not win last time gets the port.
    assign pick_d  = bus.d_req & (~bus.if_req | ~last_grant_reg);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_any) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (cnt_reg == 4'd1) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_en = 1'b0;
        bus.if_ack = 1'b0;
        bus.d_ack  = 1'b0;
        case (state_reg)
            ISSUE: bus.mem_en = 1'b1;
            ACK: begin
                bus.if_ack = ~last_grant_reg;
                bus.d_ack  = last_grant_reg;
            end
            default: ;
        endcase
    end

    assign bus.mem_we    = we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.if_stall  = bus.if_req & ~bus.if_ack;
    assign bus.d_stall   = bus.d_req & ~bus.d_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= 4'd0;
            last_grant_reg <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            if_rdata_reg   <= 32'd0;
            d_rdata_reg    <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: if (req_any) begin
                    last_grant_reg <= pick_d;
                    addr_reg       <= pick_d ? bus.d_addr : bus.if_addr;
                    we_reg         <= pick_d & bus.d_we;
                    wdata_reg      <= pick_d ? bus.d_wdata : 32'd0;
                end
                ISSUE: cnt_reg <= LAT_CNT;
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    // Last wait cycle: the memory word is valid now.
                    if (cnt_reg == 4'd1) begin
                        if (last_grant_reg) d_rdata_reg  <= we_reg ? 32'd0 : bus.mem_rdata;
                        else                if_rdata_reg <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random requester traffic against a cycle-timeline reference model, plus a
// directed single fetch on a MEM_LAT=1 instance.
module tb_mem_port_arbiter;
    localparam int LAT  = 2;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if m0 ();
    mem_port_arbiter_if m1 ();

    mem_port_arbiter #(.MEM_LAT(LAT)) dut0 (.clk(clk), .reset(reset), .bus(m0));
    mem_port_arbiter #(.MEM_LAT(1))   dut1 (.clk(clk), .reset(reset), .bus(m1));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Reference model: absolute cycle numbers of the current transaction.
    int          free_at, issue_at, ack_at, pend_at, n_txn;
    logic        g_d, g_we, last_d, h_we;
    logic [31:0] g_addr, g_wdata, h_addr, h_wdata, exp_ifrd, exp_drd, pend_addr;

    task automatic idle_inputs();
        m0.if_req = 1'b0; m0.if_addr = '0; m0.d_req = 1'b0; m0.d_we = 1'b0;
        m0.d_addr = '0;   m0.d_wdata = '0; m0.mem_rdata = '0;
        m1.if_req = 1'b0; m1.if_addr = '0; m1.d_req = 1'b0; m1.d_we = 1'b0;
        m1.d_addr = '0;   m1.d_wdata = '0; m1.mem_rdata = '0;
    endtask

    task automatic step_model(input int t, input logic rst_now);
        logic exp_ifa, exp_da;
        exp_ifa = (t == ack_at) && !g_d;
        exp_da  = (t == ack_at) && g_d;
        if (t == issue_at) begin
            h_addr = g_addr; h_we = g_we; h_wdata = g_wdata;
        end
        if (t == ack_at) begin
            if (g_d) exp_drd  = g_we ? 32'd0 : memf(g_addr);
            else     exp_ifrd = memf(g_addr);
            n_txn++;
            $display("txn %0d cycle %0d: %s we=%0d addr=0x%08h rdata=0x%08h",
                     n_txn, t, g_d ? "D " : "IF", g_we, g_addr, g_d ? exp_drd : exp_ifrd);
        end
        check_eq("mem_en",    32'(m0.mem_en),   32'(t == issue_at));
        check_eq("mem_addr",  m0.mem_addr,      h_addr);
        check_eq("mem_we",    32'(m0.mem_we),   32'(h_we));
        check_eq("mem_wdata", m0.mem_wdata,     h_wdata);
        check_eq("if_ack",    32'(m0.if_ack),   32'(exp_ifa));
        check_eq("d_ack",     32'(m0.d_ack),    32'(exp_da));
        check_eq("if_rdata",  m0.if_rdata,      exp_ifrd);
        check_eq("d_rdata",   m0.d_rdata,       exp_drd);
        check_eq("if_stall",  32'(m0.if_stall), 32'(m0.if_req & ~exp_ifa));
        check_eq("d_stall",   32'(m0.d_stall),  32'(m0.d_req & ~exp_da));

        if (rst_now) begin
            free_at = t + 1; issue_at = -1; ack_at = -1; pend_at = -1; last_d = 1'b0;
            h_addr = '0; h_we = 1'b0; h_wdata = '0; exp_ifrd = '0; exp_drd = '0;
        end else if (t >= free_at && (m0.if_req || m0.d_req)) begin
            g_d      = m0.d_req && (!m0.if_req || !last_d);
            g_addr   = g_d ? m0.d_addr : m0.if_addr;
            g_we     = g_d && m0.d_we;
            g_wdata  = g_d ? m0.d_wdata : 32'd0;
            last_d   = g_d;
            issue_at = t + 1;
            ack_at   = t + 2 + LAT;
            free_at  = t + 3 + LAT;
        end
    endtask

    initial begin
        logic if_ack_seen, d_ack_seen, did_rst;
        int   hold;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_en",   32'(m0.mem_en), 32'd0);
        check_eq("rst_mem_addr", m0.mem_addr,    32'd0);
        check_eq("rst_mem_we",   32'(m0.mem_we), 32'd0);
        check_eq("rst_if_ack",   32'(m0.if_ack), 32'd0);
        check_eq("rst_d_ack",    32'(m0.d_ack),  32'd0);
        check_eq("rst_if_rdata", m0.if_rdata,    32'd0);
        check_eq("rst_d_rdata",  m0.d_rdata,     32'd0);

        // Directed single fetch on the MEM_LAT=1 instance.
        @(posedge clk); #1;
        reset = 1'b0;
        m1.if_req = 1'b1; m1.if_addr = 32'h0000_0040;
        @(negedge clk);
        check_eq("l1_c0_mem_en",   32'(m1.mem_en),   32'd0);
        check_eq("l1_c0_if_stall", 32'(m1.if_stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("l1_c1_mem_en",   32'(m1.mem_en), 32'd1);
        check_eq("l1_c1_mem_addr", m1.mem_addr,    32'h0000_0040);
        check_eq("l1_c1_mem_we",   32'(m1.mem_we), 32'd0);
        @(posedge clk); #1;
        m1.mem_rdata = 32'h8C22_0004;
        @(negedge clk);
        check_eq("l1_c2_mem_en", 32'(m1.mem_en), 32'd0);
        check_eq("l1_c2_if_ack", 32'(m1.if_ack), 32'd0);
        @(posedge clk); #1;
        m1.mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check_eq("l1_c3_if_ack",   32'(m1.if_ack),   32'd1);
        check_eq("l1_c3_d_ack",    32'(m1.d_ack),    32'd0);
        check_eq("l1_c3_if_rdata", m1.if_rdata,      32'h8C22_0004);
        check_eq("l1_c3_if_stall", 32'(m1.if_stall), 32'd0);
        $display("txn lat1 cycle 3: IF addr=0x%08h rdata=0x%08h", m1.if_addr, m1.if_rdata);
        @(posedge clk); #1;
        m1.if_req = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Random phase on the MEM_LAT=2 instance; cycle 0 is a conflict right after reset.
        free_at = 0; issue_at = -1; ack_at = -1; pend_at = -1; n_txn = 0;
        last_d = 1'b0; g_d = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
        h_addr = '0; h_we = 1'b0; h_wdata = '0; exp_ifrd = '0; exp_drd = '0; pend_addr = '0;
        did_rst = 1'b0; hold = 0;
        m0.if_req = 1'b1; m0.if_addr = 32'h0000_0040;
        m0.d_req = 1'b1; m0.d_we = 1'b0; m0.d_addr = 32'h0000_0100; m0.d_wdata = $urandom;
        m0.mem_rdata = $urandom;
        for (int t = 0; t < NCYC; t++) begin
            @(negedge clk);
            if_ack_seen = m0.if_ack;
            d_ack_seen  = m0.d_ack;
            if (m0.mem_en) begin
                pend_addr = m0.mem_addr;
                pend_at   = t + LAT;
            end
            step_model(t, reset);
            @(posedge clk); #1;
            if (!did_rst && t + 1 >= NCYC / 2 && t + 1 == issue_at + 1) begin
                did_rst = 1'b1; reset = 1'b1; hold = 2;
                m0.if_req = 1'b1;
                if (!m0.d_req) begin
                    m0.d_req = 1'b1; m0.d_we = 1'(($urandom_range(0, 1)));
                    m0.d_addr = $urandom; m0.d_wdata = $urandom;
                end
            end else begin
                reset = 1'b0;
                if (hold > 0) begin
                    hold--;
                end else begin
                    if (!m0.if_req || if_ack_seen) begin
                        m0.if_req = ($urandom_range(0, 9) < 6);
                        m0.if_addr = $urandom;
                    end else if ($urandom_range(0, 31) == 0) begin
                        m0.if_req = 1'b0;
                    end
                    if (!m0.d_req || d_ack_seen) begin
                        m0.d_req = ($urandom_range(0, 9) < 6);
                        m0.d_we = 1'(($urandom_range(0, 1)));
                        m0.d_addr = $urandom;
                        m0.d_wdata = $urandom;
                    end else if ($urandom_range(0, 31) == 0) begin
                        m0.d_req = 1'b0;
                    end
                end
            end
            m0.mem_rdata = (t + 1 == pend_at) ? memf(pend_addr) : $urandom;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
